// File: rtl/mem_lsu.sv
// Memory stage of the five-stage pipeline: EX/MEM register, load/store over a
// req/ack data bus with byte-lane steering, misalignment drop and ack timeout.
module mem_lsu #(
   parameter int DMEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_wvalid,
   input  logic [4:0]  ex_waddr,
   input  logic [31:0] ex_wdata,
   input  logic [31:0] ex_mem_addr,
   input  logic [2:0]  ex_alusel,
   input  logic [6:0]  ex_aluop,
   input  logic [31:0] ex_r2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_req,
   output logic        wb_wvalid,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        misalign_o,
   output logic        bus_err
);

   localparam logic [2:0] ALUSEL_LOAD  = 3'd1;
   localparam logic [2:0] ALUSEL_STORE = 3'd2;

   localparam logic [6:0] OP_LB  = 7'h10;
   localparam logic [6:0] OP_LH  = 7'h11;
   localparam logic [6:0] OP_LW  = 7'h12;
   localparam logic [6:0] OP_LBU = 7'h13;
   localparam logic [6:0] OP_LHU = 7'h14;
   localparam logic [6:0] OP_SB  = 7'h18;
   localparam logic [6:0] OP_SH  = 7'h19;
   localparam logic [6:0] OP_SW  = 7'h1A;

   localparam logic [7:0] CNT_LAST = 8'(DMEM_TIMEOUT - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   // size: 0 = byte, 1 = half, 2 = word
   typedef struct packed {
      logic       valid;
      logic       load;
      logic [1:0] size;
      logic       sext;
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [2:0] sel, input logic [6:0] op);
      mem_op_t d;
      d = '0;
      if (sel == ALUSEL_LOAD) begin
         case (op)
            OP_LB:   d = '{valid: 1'b1, load: 1'b1, size: 2'd0, sext: 1'b1};
            OP_LH:   d = '{valid: 1'b1, load: 1'b1, size: 2'd1, sext: 1'b1};
            OP_LW:   d = '{valid: 1'b1, load: 1'b1, size: 2'd2, sext: 1'b0};
            OP_LBU:  d = '{valid: 1'b1, load: 1'b1, size: 2'd0, sext: 1'b0};
            OP_LHU:  d = '{valid: 1'b1, load: 1'b1, size: 2'd1, sext: 1'b0};
            default: d = '0;
         endcase
      end else if (sel == ALUSEL_STORE) begin
         case (op)
            OP_SB:   d = '{valid: 1'b1, load: 1'b0, size: 2'd0, sext: 1'b0};
            OP_SH:   d = '{valid: 1'b1, load: 1'b0, size: 2'd1, sext: 1'b0};
            OP_SW:   d = '{valid: 1'b1, load: 1'b0, size: 2'd2, sext: 1'b0};
            default: d = '0;
         endcase
      end
      return d;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd1:    return a[0];
         2'd2:    return a != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        s_wvalid_q, s_wvalid_d;
   logic [4:0]  s_waddr_q, s_waddr_d;
   logic [31:0] s_wdata_q, s_wdata_d;
   logic [1:0]  s_lane_q, s_lane_d;
   logic        s_memsel_q, s_memsel_d;
   mem_op_t     s_op_q, s_op_d;

   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;

   logic        wb_wvalid_q, wb_wvalid_d;
   logic [4:0]  wb_waddr_q, wb_waddr_d;
   logic [31:0] wb_wdata_q, wb_wdata_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   mem_op_t     ex_op;
   logic        ex_memsel;
   logic        ex_start;
   logic        access;
   logic        timeout_hit;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   assign ex_op       = decode_op(ex_alusel, ex_aluop);
   assign ex_memsel   = (ex_alusel == ALUSEL_LOAD) || (ex_alusel == ALUSEL_STORE);
   assign ex_start    = ex_op.valid && !is_misaligned(ex_op.size, ex_mem_addr[1:0]);
   assign access      = (state_q == ACCESS);
   assign timeout_hit = access && (cnt_q == CNT_LAST) && !dmem_ack;
   assign stall_req   = access && !dmem_ack && !timeout_hit;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = ex_r2;
      case (ex_op.size)
         2'd0: begin
            st_be    = 4'b0001 << ex_mem_addr[1:0];
            st_wdata = {4{ex_r2[7:0]}};
         end
         2'd1: begin
            st_be    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ex_r2[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata[{s_lane_q, 3'b000} +: 8];
      ld_half = dmem_rdata[{s_lane_q[1], 4'b0000} +: 16];
      case (s_op_q.size)
         2'd0:    load_data = {{24{s_op_q.sext & ld_byte[7]}}, ld_byte};
         2'd1:    load_data = {{16{s_op_q.sext & ld_half[15]}}, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   // Capture and bus launch happen together whenever the stage is not stalled,
   // so a new access can start on the same edge that completes the previous one.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      s_wvalid_d   = s_wvalid_q;
      s_waddr_d    = s_waddr_q;
      s_wdata_d    = s_wdata_q;
      s_lane_d     = s_lane_q;
      s_memsel_d   = s_memsel_q;
      s_op_d       = s_op_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      wb_wvalid_d  = 1'b0;
      wb_waddr_d   = s_waddr_q;
      wb_wdata_d   = s_wdata_q;
      misalign_d   = 1'b0;
      bus_err_d    = 1'b0;

      if (stall_req) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         s_wvalid_d   = ex_wvalid;
         s_waddr_d    = ex_waddr;
         s_wdata_d    = ex_wdata;
         s_lane_d     = ex_mem_addr[1:0];
         s_memsel_d   = ex_memsel;
         s_op_d       = ex_op;
         state_d      = ex_start ? ACCESS : IDLE;
         cnt_d        = '0;
         dmem_req_d   = ex_start;
         dmem_we_d    = ex_start && !ex_op.load;
         dmem_addr_d  = ex_start ? {ex_mem_addr[31:2], 2'b00} : '0;
         dmem_be_d    = ex_start ? st_be : '0;
         dmem_wdata_d = (ex_start && !ex_op.load) ? st_wdata : '0;
      end

      if (access) begin
         if (dmem_ack) begin
            if (s_op_q.load) begin
               wb_wvalid_d = s_wvalid_q;
               wb_wdata_d  = load_data;
            end
         end else if (timeout_hit) begin
            bus_err_d = 1'b1;
         end
      end else if (!s_memsel_q) begin
         wb_wvalid_d = s_wvalid_q;
      end else begin
         misalign_d = s_op_q.valid && is_misaligned(s_op_q.size, s_lane_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         s_wvalid_q   <= 1'b0;
         s_waddr_q    <= '0;
         s_wdata_q    <= '0;
         s_lane_q     <= '0;
         s_memsel_q   <= 1'b0;
         s_op_q       <= '0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
         wb_wvalid_q  <= 1'b0;
         wb_waddr_q   <= '0;
         wb_wdata_q   <= '0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s_wvalid_q   <= s_wvalid_d;
         s_waddr_q    <= s_waddr_d;
         s_wdata_q    <= s_wdata_d;
         s_lane_q     <= s_lane_d;
         s_memsel_q   <= s_memsel_d;
         s_op_q       <= s_op_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         wb_wvalid_q  <= wb_wvalid_d;
         wb_waddr_q   <= wb_waddr_d;
         wb_wdata_q   <= wb_wdata_d;
         misalign_q   <= misalign_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;
   assign wb_wvalid  = wb_wvalid_q;
   assign wb_waddr   = wb_waddr_q;
   assign wb_wdata   = wb_wdata_q;
   assign misalign_o = misalign_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed table plus randomized ops, all checked
// cycle by cycle against a schedule derived from the load/store rules.
module tb_mem_lsu;

   localparam int TMO = 4;

   localparam logic [2:0] SEL_NOP   = 3'd0;
   localparam logic [2:0] SEL_LOAD  = 3'd1;
   localparam logic [2:0] SEL_STORE = 3'd2;
   localparam logic [2:0] SEL_ALU   = 3'd3;

   localparam logic [6:0] OP_LB  = 7'h10;
   localparam logic [6:0] OP_LH  = 7'h11;
   localparam logic [6:0] OP_LW  = 7'h12;
   localparam logic [6:0] OP_LBU = 7'h13;
   localparam logic [6:0] OP_LHU = 7'h14;
   localparam logic [6:0] OP_SB  = 7'h18;
   localparam logic [6:0] OP_SH  = 7'h19;
   localparam logic [6:0] OP_SW  = 7'h1A;
   localparam logic [6:0] OP_BAD = 7'h7F;

   typedef struct {
      logic [2:0]  alusel;
      logic [6:0]  aluop;
      logic [31:0] addr;
      logic [31:0] r2;
      logic        wvalid;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic        expReq;
      logic        expWe;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic [31:0] expBusData;
      logic        expWbValid;
      logic [31:0] expWbData;
      logic        expMisalign;
      logic        expBusErr;
   } vec_t;

   typedef struct {
      int vi;
      bit last;
      bit ack;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_wvalid;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [31:0] ex_mem_addr;
   logic [2:0]  ex_alusel;
   logic [6:0]  ex_aluop;
   logic [31:0] ex_r2;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall_req;
   logic        wb_wvalid;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        misalign_o;
   logic        bus_err;

   int errors = 0;
   int checks = 0;
   vec_t stream[$];
   vec_t nopVec;
   vec_t dirTable[15];

   mem_lsu #(.DMEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ex_wvalid(ex_wvalid), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ex_mem_addr(ex_mem_addr), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop), .ex_r2(ex_r2),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall_req(stall_req), .wb_wvalid(wb_wvalid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .misalign_o(misalign_o), .bus_err(bus_err)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [2:0] sel, input logic [6:0] op, input logic [31:0] addr,
                                  input logic [31:0] r2, input logic wv, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic [31:0] rd, input int waits);
      vec_t v;
      v = '{default: '0};
      v.alusel = sel; v.aluop = op; v.addr = addr; v.r2 = r2;
      v.wvalid = wv; v.waddr = wa; v.wdata = wd; v.rdata = rd; v.waits = waits;
      return v;
   endfunction

   function automatic vec_t withExp(input vec_t vin, input logic req, input logic we, input logic [31:0] a,
                                    input logic [3:0] be, input logic [31:0] bd, input logic wbv,
                                    input logic [31:0] wbd, input logic mis, input logic berr);
      vec_t v;
      v = vin;
      v.expReq = req; v.expWe = we; v.expAddr = a; v.expBe = be; v.expBusData = bd;
      v.expWbValid = wbv; v.expWbData = wbd; v.expMisalign = mis; v.expBusErr = berr;
      return v;
   endfunction

   // Reference model: derives bus and write-back results from access size,
   // offset and signedness using plain arithmetic.
   function automatic vec_t modelExpect(input vec_t vin);
      vec_t v;
      int size;
      int off;
      bit isLoad;
      bit isSigned;
      logic [31:0] mask;
      logic [31:0] val;
      v = withExp(vin, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      size = 0; isLoad = 0; isSigned = 0;
      if (v.alusel == SEL_LOAD) begin
         isLoad = 1;
         case (v.aluop)
            OP_LB:  begin size = 1; isSigned = 1; end
            OP_LH:  begin size = 2; isSigned = 1; end
            OP_LW:  size = 4;
            OP_LBU: size = 1;
            OP_LHU: size = 2;
            default: size = 0;
         endcase
      end else if (v.alusel == SEL_STORE) begin
         case (v.aluop)
            OP_SB: size = 1;
            OP_SH: size = 2;
            OP_SW: size = 4;
            default: size = 0;
         endcase
      end
      if (v.alusel != SEL_LOAD && v.alusel != SEL_STORE) begin
         v.expWbValid = v.wvalid;
         v.expWbData  = v.wdata;
      end else if (size == 0) begin
         v.expWbValid = 0;
      end else if (int'(v.addr % 4) % size != 0) begin
         v.expMisalign = 1;
      end else begin
         off = int'(v.addr % 4);
         v.expReq  = 1;
         v.expWe   = !isLoad;
         v.expAddr = v.addr - (v.addr % 4);
         v.expBe   = 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++) v.expBusData[8*i +: 8] = v.r2[8*(i % size) +: 8];
         if (v.waits < 0) begin
            v.expBusErr = 1;
         end else if (isLoad) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            val  = (v.rdata >> (8*off)) & mask;
            if (isSigned && val[8*size-1]) val = val | ~mask;
            v.expWbValid = v.wvalid;
            v.expWbData  = val;
         end
      end
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      ex_alusel   = v.alusel;
      ex_aluop    = v.aluop;
      ex_mem_addr = v.addr;
      ex_r2       = v.r2;
      ex_wvalid   = v.wvalid;
      ex_waddr    = v.waddr;
      ex_wdata    = v.wdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkWb(input cyc_t c);
      vec_t v;
      v = stream[c.vi];
      if (c.last) begin
         checkOutput($sformatf("op%0d wb_wvalid", c.vi), wb_wvalid, v.expWbValid);
         if (v.expWbValid) begin
            checkOutput($sformatf("op%0d wb_waddr", c.vi), wb_waddr, v.waddr);
            checkOutput($sformatf("op%0d wb_wdata", c.vi), wb_wdata, v.expWbData);
         end
         checkOutput($sformatf("op%0d misalign_o", c.vi), misalign_o, v.expMisalign);
         checkOutput($sformatf("op%0d bus_err", c.vi), bus_err, v.expBusErr);
      end else begin
         checkOutput($sformatf("op%0d wb_wvalid bubble", c.vi), wb_wvalid, 0);
         checkOutput($sformatf("op%0d misalign_o bubble", c.vi), misalign_o, 0);
         checkOutput($sformatf("op%0d bus_err bubble", c.vi), bus_err, 0);
      end
   endtask

   // Expands the op stream into a per-cycle schedule: a memory op occupies
   // waits+1 cycles (or TMO cycles when never acked), everything else one cycle.
   // While an op is in flight the next op is held on ex_*, as a frozen pipeline would.
   task automatic runStream();
      cyc_t cycs[$];
      cyc_t prev;
      bit havePrev;
      vec_t v;
      int n;
      foreach (stream[i]) begin
         n = stream[i].expReq ? ((stream[i].waits < 0) ? TMO : stream[i].waits + 1) : 1;
         for (int k = 0; k < n; k++)
            cycs.push_back('{vi: i, last: (k == n - 1),
                             ack: stream[i].expReq && (stream[i].waits >= 0) && (k == n - 1)});
      end
      @(negedge clk);
      applyStimulus(stream[0]);
      dmem_ack = 1'b0;
      @(posedge clk);
      havePrev = 0;
      foreach (cycs[j]) begin
         @(negedge clk);
         v = stream[cycs[j].vi];
         applyStimulus((cycs[j].vi + 1 < stream.size()) ? stream[cycs[j].vi + 1] : nopVec);
         dmem_ack   = cycs[j].ack;
         dmem_rdata = cycs[j].ack ? v.rdata : $urandom;
         #1;
         if (havePrev) checkWb(prev);
         checkOutput($sformatf("op%0d stall_req", cycs[j].vi), stall_req, !cycs[j].last);
         checkOutput($sformatf("op%0d dmem_req", cycs[j].vi), dmem_req, v.expReq);
         if (v.expReq) begin
            checkOutput($sformatf("op%0d dmem_we", cycs[j].vi), dmem_we, v.expWe);
            checkOutput($sformatf("op%0d dmem_addr", cycs[j].vi), dmem_addr, v.expAddr);
            checkOutput($sformatf("op%0d dmem_be", cycs[j].vi), dmem_be, v.expBe);
            if (v.expWe)
               checkOutput($sformatf("op%0d dmem_wdata", cycs[j].vi), dmem_wdata, v.expBusData);
         end
         prev = cycs[j];
         havePrev = 1;
      end
      @(negedge clk);
      applyStimulus(nopVec);
      dmem_ack = 1'b0;
      #1;
      checkWb(prev);
   endtask

   // Main sequence: reset state, directed table, mid-access reset, random ops
   initial begin
      vec_t rv;
      vec_t lw;
      logic [6:0] opList[8];
      logic [2:0] selList[8];
      int sizeList[8];
      int pick;

      opList   = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      selList  = '{SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_STORE, SEL_STORE, SEL_STORE};
      sizeList = '{1, 2, 4, 1, 2, 1, 2, 4};

      nopVec = mkVec(SEL_NOP, 7'h00, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      applyStimulus(nopVec);
      dmem_ack   = 1'b0;
      dmem_rdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset dmem_req", dmem_req, 0);
      checkOutput("reset dmem_we", dmem_we, 0);
      checkOutput("reset dmem_addr", dmem_addr, 0);
      checkOutput("reset dmem_be", dmem_be, 0);
      checkOutput("reset dmem_wdata", dmem_wdata, 0);
      checkOutput("reset stall_req", stall_req, 0);
      checkOutput("reset wb_wvalid", wb_wvalid, 0);
      checkOutput("reset wb_waddr", wb_waddr, 0);
      checkOutput("reset wb_wdata", wb_wdata, 0);
      checkOutput("reset misalign_o", misalign_o, 0);
      checkOutput("reset bus_err", bus_err, 0);
      rst = 1'b0;

      dirTable[0]  = withExp(mkVec(SEL_ALU, 7'h00, 0, 0, 1, 5, 32'h12, 0, 0),
                             0, 0, 0, 0, 0, 1, 32'h0000_0012, 0, 0);
      dirTable[1]  = withExp(mkVec(SEL_LOAD, OP_LB, 32'h1003, 0, 1, 7, 0, 32'h80FF_1234, 0),
                             1, 0, 32'h1000, 4'b1000, 0, 1, 32'hFFFF_FF80, 0, 0);
      dirTable[2]  = withExp(mkVec(SEL_LOAD, OP_LBU, 32'h1003, 0, 1, 8, 0, 32'h80FF_1234, 0),
                             1, 0, 32'h1000, 4'b1000, 0, 1, 32'h0000_0080, 0, 0);
      dirTable[3]  = withExp(mkVec(SEL_STORE, OP_SH, 32'h2002, 32'hABCD_1234, 1, 9, 0, 0, 3),
                             1, 1, 32'h2000, 4'b1100, 32'h1234_1234, 0, 0, 0, 0);
      dirTable[4]  = withExp(mkVec(SEL_ALU, 7'h01, 0, 0, 1, 10, 32'hDEAD_BEEF, 0, 0),
                             0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      dirTable[5]  = withExp(mkVec(SEL_LOAD, OP_LW, 32'h3001, 0, 1, 11, 0, 0, 0),
                             0, 0, 0, 0, 0, 0, 0, 1, 0);
      dirTable[6]  = withExp(mkVec(SEL_LOAD, OP_LW, 32'h4000, 0, 1, 12, 0, 0, -1),
                             1, 0, 32'h4000, 4'b1111, 0, 0, 0, 0, 1);
      dirTable[7]  = withExp(mkVec(SEL_LOAD, OP_LH, 32'h5002, 0, 1, 13, 0, 32'h8001_7FFF, 1),
                             1, 0, 32'h5000, 4'b1100, 0, 1, 32'hFFFF_8001, 0, 0);
      dirTable[8]  = withExp(mkVec(SEL_LOAD, OP_LHU, 32'h5000, 0, 1, 14, 0, 32'h1234_9ABC, 2),
                             1, 0, 32'h5000, 4'b0011, 0, 1, 32'h0000_9ABC, 0, 0);
      dirTable[9]  = withExp(mkVec(SEL_STORE, OP_SB, 32'h6001, 32'h0000_00A5, 1, 15, 0, 0, 0),
                             1, 1, 32'h6000, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0);
      dirTable[10] = withExp(mkVec(SEL_STORE, OP_SW, 32'h7000, 32'h0123_4567, 1, 16, 0, 0, 0),
                             1, 1, 32'h7000, 4'b1111, 32'h0123_4567, 0, 0, 0, 0);
      dirTable[11] = withExp(mkVec(SEL_LOAD, OP_LW, 32'h8000, 0, 1, 17, 0, 32'hCAFE_F00D, 0),
                             1, 0, 32'h8000, 4'b1111, 0, 1, 32'hCAFE_F00D, 0, 0);
      dirTable[12] = withExp(mkVec(SEL_LOAD, OP_LH, 32'h5001, 0, 1, 18, 0, 0, 0),
                             0, 0, 0, 0, 0, 0, 0, 1, 0);
      dirTable[13] = withExp(mkVec(SEL_LOAD, OP_BAD, 32'h9000, 0, 1, 19, 32'h44, 0, 0),
                             0, 0, 0, 0, 0, 0, 0, 0, 0);
      dirTable[14] = withExp(mkVec(SEL_ALU, 7'h02, 0, 0, 0, 3, 32'h77, 0, 0),
                             0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] directed table");
      stream.delete();
      foreach (dirTable[i]) stream.push_back(dirTable[i]);
      runStream();

      $display("[TB] reset during an access");
      lw = mkVec(SEL_LOAD, OP_LW, 32'h9000, 0, 1, 12, 32'h55, 0, -1);
      @(negedge clk);
      applyStimulus(lw);
      dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      applyStimulus(nopVec);
      #1;
      checkOutput("rstmid first wait dmem_req", dmem_req, 1);
      checkOutput("rstmid first wait stall_req", stall_req, 1);
      @(negedge clk);
      #1;
      checkOutput("rstmid second wait stall_req", stall_req, 1);
      rst = 1'b1;
      #1;
      checkOutput("rstmid dmem_req", dmem_req, 0);
      checkOutput("rstmid stall_req", stall_req, 0);
      checkOutput("rstmid wb_wvalid", wb_wvalid, 0);
      checkOutput("rstmid wb_waddr", wb_waddr, 0);
      checkOutput("rstmid wb_wdata", wb_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      stream.delete();
      stream.push_back(withExp(mkVec(SEL_ALU, 7'h00, 0, 0, 1, 21, 32'h1357_2468, 0, 0),
                               0, 0, 0, 0, 0, 1, 32'h1357_2468, 0, 0));
      runStream();

      $display("[TB] randomized ops");
      stream.delete();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 99) < 30) begin
            pick = $urandom_range(0, 5);
            rv = mkVec((pick == 0) ? SEL_NOP : 3'(pick + 2), 7'($urandom), $urandom, $urandom,
                       1'($urandom), 5'($urandom), $urandom, $urandom, 0);
         end else begin
            pick = $urandom_range(0, 7);
            rv = mkVec(selList[pick], opList[pick], $urandom, $urandom, 1'($urandom), 5'($urandom),
                       $urandom, $urandom, 0);
            if ($urandom_range(0, 19) == 0) rv.aluop = OP_BAD;
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~32'(sizeList[pick] - 1);
            rv.waits = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 3));
         end
         stream.push_back(modelExpect(rv));
      end
      runStream();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
